gs_rd_port_arb: RTL and testbench

- Two-requester arbiter sharing one mem_wrap read port (enb/addrb/doutb/validb) between the 5x5 Gauss filter engine (req 0) and the host/readout path (req 1).
- Lets the result RAM be read by the filter during its second pass and by the frame-export logic without a third RAM port.
- Provides round-robin arbitration with optional burst lock and a starvation cap.
- Tracks in-flight reads and routes returned data back to the issuing requester.

---
 rtl/gs_filter_pkg.sv | 27 ++
 rtl/gs_rd_tag_pipe.sv | 59 +++++
 rtl/gs_rd_port_arb.sv | 158 +++++++++++++++
 tb/tb_gs_rd_port_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_filter_pkg.sv
// Shared definitions for the 5x5 Gauss filter codebase slice.
//   GS_AW / GS_DW   : result RAM read address / data widths
//   GS_RD_LAT       : mem_wrap read latency (enb -> validb)
//   REQ_FILT/HOST   : requester ids on the shared read port
//   arb_state_e     : read-port arbiter state encoding
//   rd_tag_t        : one in-flight read tag {valid, requester id}
package gs_filter_pkg;

  localparam int GS_AW     = 16;
  localparam int GS_DW     = 8;
  localparam int GS_RD_LAT = 1;

  localparam logic REQ_FILT = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic v;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/gs_rd_tag_pipe.sv
// In-flight read tracker for one mem_wrap read port.
// An RD_LAT-deep shift register of {v, id} tags; the tail entry lines up
// with the memory's valid strobe, so it tells who owns the returning data.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   issue_v      : a read is issued to the memory this cycle
//   issue_id     : requester id of that read
//   mem_valid    : memory returned data this cycle
//   tail_v       : a read is due back this cycle
//   tail_id      : requester id of the read due back
//   any_v        : at least one read is in flight
//   err          : sticky; stray data or lost read seen
module gs_rd_tag_pipe
  import gs_filter_pkg::*;
#(
  parameter int RD_LAT = GS_RD_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue_v,
  input  logic issue_id,
  input  logic mem_valid,
  output logic tail_v,
  output logic tail_id,
  output logic any_v,
  output logic err
);

  rd_tag_t [RD_LAT-1:0] tags;

  // Shift the tag chain every cycle; a mismatch between the tail and the
  // memory's valid strobe means data arrived with nobody waiting for it or
  // an expected read never came back. Either way the flag sticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags <= '0;
      err  <= 1'b0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tags[i] <= tags[i-1];
      end
      tags[0] <= '{v: issue_v, id: issue_id};
      if (mem_valid != tags[RD_LAT-1].v) begin
        err <= 1'b1;
      end
    end
  end

  assign tail_v  = tags[RD_LAT-1].v;
  assign tail_id = tags[RD_LAT-1].id;

  always_comb begin
    any_v = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      any_v = any_v | tags[i].v;
    end
  end

endmodule

// File: rtl/gs_rd_port_arb.sv
// Two-requester arbiter for a single mem_wrap read port.
// Requester 0 is the Gauss filter engine, requester 1 the host readout path.
// Round-robin between the two, with an optional per-requester lock that
// keeps ownership for a burst (capped at MAX_BURST grants), and return-data
// routing back to whichever requester issued each read.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   reqN/addrN/lockN        : read request, address, keep-ownership hint
//   gntN                    : read accepted this cycle (combinational)
//   rvalidN                 : rdata belongs to requester N this cycle
//   rdata                   : shared return data
//   mem_en/mem_addr         : to mem_wrap enb/addrb
//   mem_data/mem_valid      : from mem_wrap doutb/validb
//   busy                    : reads in flight or a lock is held
//   err                     : sticky protocol error
module gs_rd_port_arb
  import gs_filter_pkg::*;
#(
  parameter int AW        = GS_AW,
  parameter int DW        = GS_DW,
  parameter int RD_LAT    = GS_RD_LAT,
  parameter int MAX_BURST = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          lock0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic          lock1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          mem_valid,
  output logic          busy,
  output logic          err
);

  localparam int            CW          = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);
  localparam logic [CW-1:0] BURST_ONE   = CW'(1);

  arb_state_e    state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] burst_q, burst_d, burst_inc;
  logic [AW-1:0] addr_q;
  logic          own_id, own_req, own_lock;
  logic          tail_v, tail_id, tags_busy;

  assign burst_inc = burst_q + BURST_ONE;
  assign own_id    = (state_q == ST_OWN1);
  assign own_req   = own_id ? req1 : req0;
  assign own_lock  = own_id ? lock1 : lock0;

  // Grant and next-state logic. In IDLE the round-robin pointer only breaks
  // ties; in OWNn the other requester is simply ignored. A lock that hits
  // MAX_BURST drops back to IDLE with the pointer aimed at the waiting side,
  // so a capped burst always yields the next contended slot.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 && (!req1 || rr_ptr_q == REQ_FILT)) begin
          gnt0 = 1'b1;
        end else if (req1) begin
          gnt1 = 1'b1;
        end
        if (gnt0 || gnt1) begin
          rr_ptr_d = gnt0 ? REQ_HOST : REQ_FILT;
          // With MAX_BURST=1 the first grant already exhausts the burst.
          if (MAX_BURST > 1) begin
            if (gnt0 && lock0) begin
              state_d = ST_OWN0;
              burst_d = BURST_ONE;
            end else if (gnt1 && lock1) begin
              state_d = ST_OWN1;
              burst_d = BURST_ONE;
            end
          end
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_req) begin
          state_d = ST_IDLE;
          burst_d = '0;
        end else begin
          gnt0 = ~own_id;
          gnt1 = own_id;
          if (!own_lock) begin
            state_d = ST_IDLE;
            burst_d = '0;
          end else if (burst_inc == BURST_LIMIT) begin
            state_d  = ST_IDLE;
            burst_d  = '0;
            rr_ptr_d = ~own_id;
          end else begin
            burst_d = burst_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        burst_d = '0;
      end
    endcase
  end

  // Arbiter state, plus the last issued address so mem_addr holds steady
  // on cycles without a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= REQ_FILT;
      burst_q  <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      if (mem_en) begin
        addr_q <= mem_addr;
      end
    end
  end

  assign mem_en   = gnt0 | gnt1;
  assign mem_addr = gnt0 ? addr0 : (gnt1 ? addr1 : addr_q);

  gs_rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue_v  (mem_en),
    .issue_id (gnt1),
    .mem_valid(mem_valid),
    .tail_v   (tail_v),
    .tail_id  (tail_id),
    .any_v    (tags_busy),
    .err      (err)
  );

  assign rdata   = mem_data;
  assign rvalid0 = mem_valid & tail_v & (tail_id == REQ_FILT);
  assign rvalid1 = mem_valid & tail_v & (tail_id == REQ_HOST);
  assign busy    = tags_busy | (state_q != ST_IDLE);

endmodule

// File: tb/tb_gs_rd_port_arb.sv
// Bench for gs_rd_port_arb. Two instances share one stimulus stream:
// dut_a with MAX_BURST=64 and dut_b with MAX_BURST=4, each with its own
// one-cycle mem_wrap emulation over a common preloaded RAM image.
module tb_gs_rd_port_arb;
  import gs_filter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0, lock0, req1, lock1, stray;
  logic [15:0] addr0, addr1;

  logic        gnt0_v [2];
  logic        gnt1_v [2];
  logic        rv0_v [2];
  logic        rv1_v [2];
  logic        en_v [2];
  logic        busy_v [2];
  logic        err_v [2];
  logic        mv_q [2];
  logic        mem_valid_v [2];
  logic [15:0] maddr_v [2];
  logic [7:0]  rdata_v [2];
  logic [7:0]  md_q [2];
  logic [7:0]  mem [65536];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_valid_v[0] = mv_q[0] | stray;
  assign mem_valid_v[1] = mv_q[1] | stray;

  // mem_wrap emulation: one cycle from enb to validb/doutb.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_q[0] <= 1'b0;
      mv_q[1] <= 1'b0;
      md_q[0] <= '0;
      md_q[1] <= '0;
    end else begin
      mv_q[0] <= en_v[0];
      mv_q[1] <= en_v[1];
      md_q[0] <= mem[maddr_v[0]];
      md_q[1] <= mem[maddr_v[1]];
    end
  end

  gs_rd_port_arb #(.AW(16), .DW(8), .RD_LAT(1), .MAX_BURST(64)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .lock0(lock0), .gnt0(gnt0_v[0]), .rvalid0(rv0_v[0]),
    .req1(req1), .addr1(addr1), .lock1(lock1), .gnt1(gnt1_v[0]), .rvalid1(rv1_v[0]),
    .rdata(rdata_v[0]), .mem_en(en_v[0]), .mem_addr(maddr_v[0]),
    .mem_data(md_q[0]), .mem_valid(mem_valid_v[0]), .busy(busy_v[0]), .err(err_v[0])
  );

  gs_rd_port_arb #(.AW(16), .DW(8), .RD_LAT(1), .MAX_BURST(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .lock0(lock0), .gnt0(gnt0_v[1]), .rvalid0(rv0_v[1]),
    .req1(req1), .addr1(addr1), .lock1(lock1), .gnt1(gnt1_v[1]), .rvalid1(rv1_v[1]),
    .rdata(rdata_v[1]), .mem_en(en_v[1]), .mem_addr(maddr_v[1]),
    .mem_data(md_q[1]), .mem_valid(mem_valid_v[1]), .busy(busy_v[1]), .err(err_v[1])
  );

  // Reference model: who owns the port, how long the current burst is,
  // who wins the next tie, and a queue of reads expected back.
  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } pend_t;

  int          max_b [2];
  int          owner [2];
  int          run_cnt [2];
  int          pref [2];
  logic [15:0] last_addr [2];
  logic        err_m [2];
  pend_t       pq [2][$];
  int          model_g [2];
  logic        obs_gnt0 [2];
  logic        obs_gnt1 [2];
  logic        obs_rv0 [2];
  logic        obs_rv1 [2];
  logic        obs_busy [2];
  logic [15:0] obs_addr [2];
  int          cyc = 0;

  typedef struct {
    logic        r0;
    logic [15:0] a0;
    logic        l0;
    logic        r1;
    logic [15:0] a1;
    logic        l1;
    logic        eg0;
    logic        eg1;
    logic [15:0] ea;
  } vec_t;

  vec_t tbl [9];

  task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [15:0] a0, input logic l0,
                               input logic r1, input logic [15:0] a1, input logic l1);
    req0  = r0;
    addr0 = a0;
    lock0 = l0;
    req1  = r1;
    addr1 = a1;
    lock1 = l1;
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      owner[k]     = -1;
      run_cnt[k]   = 0;
      pref[k]      = 0;
      last_addr[k] = '0;
      err_m[k]     = 1'b0;
      pq[k].delete();
    end
  endtask

  // Called at a negedge with inputs already applied: sample 1 time unit
  // later, compare against the model, advance the model past the next
  // posedge, then wait for the following negedge.
  task automatic runCycle();
    #1;
    for (int k = 0; k < 2; k++) begin
      int          g;
      bit          has_due;
      logic [15:0] exp_addr;
      logic        lk;
      g = -1;
      if (owner[k] < 0) begin
        if (req0 && (!req1 || pref[k] == 0)) g = 0;
        else if (req1) g = 1;
      end else if ((owner[k] == 0) ? req0 : req1) begin
        g = owner[k];
      end
      has_due  = (pq[k].size() > 0) && (pq[k][0].due == cyc);
      exp_addr = (g == 0) ? addr0 : ((g == 1) ? addr1 : last_addr[k]);

      checkOutput("gnt0", k, gnt0_v[k], g == 0);
      checkOutput("gnt1", k, gnt1_v[k], g == 1);
      checkOutput("mem_en", k, en_v[k], g >= 0);
      checkOutput("mem_addr", k, maddr_v[k], exp_addr);
      checkOutput("rvalid0", k, rv0_v[k], has_due && pq[k][0].id == 0);
      checkOutput("rvalid1", k, rv1_v[k], has_due && pq[k][0].id == 1);
      if (has_due) checkOutput("rdata", k, rdata_v[k], pq[k][0].data);
      checkOutput("busy", k, busy_v[k], (pq[k].size() > 0) || (owner[k] >= 0));
      checkOutput("err", k, err_v[k], err_m[k]);

      obs_gnt0[k] = gnt0_v[k];
      obs_gnt1[k] = gnt1_v[k];
      obs_rv0[k]  = rv0_v[k];
      obs_rv1[k]  = rv1_v[k];
      obs_busy[k] = busy_v[k];
      obs_addr[k] = maddr_v[k];

      if (mem_valid_v[k] != has_due) err_m[k] = 1'b1;
      if (has_due) void'(pq[k].pop_front());
      if (g >= 0) begin
        pq[k].push_back('{due: cyc + GS_RD_LAT, id: g, data: mem[exp_addr]});
        last_addr[k] = exp_addr;
      end

      lk = (g == 1) ? lock1 : lock0;
      if (owner[k] < 0) begin
        if (g >= 0) begin
          pref[k] = 1 - g;
          if (lk && max_b[k] > 1) begin
            owner[k]   = g;
            run_cnt[k] = 1;
          end
        end
      end else if (g < 0 || !lk) begin
        owner[k] = -1;
      end else begin
        run_cnt[k]++;
        if (run_cnt[k] == max_b[k]) begin
          owner[k] = -1;
          pref[k]  = 1 - g;
        end
      end
      model_g[k] = g;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic checkResetValues(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput({tag, "_gnt0"}, k, gnt0_v[k], 0);
      checkOutput({tag, "_gnt1"}, k, gnt1_v[k], 0);
      checkOutput({tag, "_rvalid0"}, k, rv0_v[k], 0);
      checkOutput({tag, "_rvalid1"}, k, rv1_v[k], 0);
      checkOutput({tag, "_mem_en"}, k, en_v[k], 0);
      checkOutput({tag, "_mem_addr"}, k, maddr_v[k], 0);
      checkOutput({tag, "_rdata"}, k, rdata_v[k], 0);
      checkOutput({tag, "_busy"}, k, busy_v[k], 0);
      checkOutput({tag, "_err"}, k, err_v[k], 0);
    end
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0);
    stray = 1'b0;
    #2 rst_n = 1'b0;
    modelReset();
    #1 checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) runCycle();
  endtask

  initial begin
    int cnt0, cnt1, f_idx, h_cnt, guard, busy_cnt, rv0_cnt, rv1_cnt;
    bit h_pend;
    logic [15:0] h_addr;

    max_b[0] = 64;
    max_b[1] = 4;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Single-requester burst, then alternating contention without locks.
    tbl[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0010};
    tbl[1] = '{1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0011};
    tbl[2] = '{1'b1, 16'h0012, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0012};
    tbl[3] = '{1'b1, 16'h0013, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0013};
    tbl[4] = '{1'b1, 16'h0020, 1'b0, 1'b1, 16'h0120, 1'b0, 1'b0, 1'b1, 16'h0120};
    tbl[5] = '{1'b1, 16'h0021, 1'b0, 1'b1, 16'h0121, 1'b0, 1'b1, 1'b0, 16'h0021};
    tbl[6] = '{1'b1, 16'h0022, 1'b0, 1'b1, 16'h0122, 1'b0, 1'b0, 1'b1, 16'h0122};
    tbl[7] = '{1'b1, 16'h0023, 1'b0, 1'b1, 16'h0123, 1'b0, 1'b1, 1'b0, 16'h0023};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0023};

    applyStimulus(0, 0, 0, 0, 0, 0);
    stray = 1'b0;
    @(negedge clk);
    doReset();

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].r0, tbl[i].a0, tbl[i].l0, tbl[i].r1, tbl[i].a1, tbl[i].l1);
      runCycle();
      for (int k = 0; k < 2; k++) begin
        checkOutput("tbl_gnt0", k, obs_gnt0[k], tbl[i].eg0);
        checkOutput("tbl_gnt1", k, obs_gnt1[k], tbl[i].eg1);
        checkOutput("tbl_addr", k, obs_addr[k], tbl[i].ea);
      end
    end
    idleCycles(2);

    $display("[TB] host lock burst");
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 16'h0030, 0, 1, 16'h0200 + 16'(i), 1);
      runCycle();
      if (obs_gnt0[0]) cnt0++;
      if (obs_gnt1[0]) cnt1++;
    end
    checkOutput("lock1_gnt1_run", 0, cnt1, 10);
    checkOutput("lock1_gnt0_held", 0, cnt0, 0);
    applyStimulus(1, 16'h0030, 0, 1, 16'h020a, 0);
    runCycle();
    checkOutput("lock1_release_gnt1", 0, obs_gnt1[0], 1);
    applyStimulus(1, 16'h0030, 0, 1, 16'h020b, 0);
    runCycle();
    checkOutput("after_release_gnt0", 0, obs_gnt0[0], 1);
    idleCycles(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom),
                    $urandom_range(0, 2) != 0, 16'($urandom), 1'($urandom));
      runCycle();
    end
    idleCycles(3);
    doReset();

    $display("[TB] burst cap");
    cnt0 = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 16'h0040 + 16'(i), 1, 1, 16'h0300, 0);
      runCycle();
      if (obs_gnt0[1]) cnt0++;
    end
    checkOutput("cap_gnt0_count", 1, cnt0, 4);
    applyStimulus(1, 16'h0044, 1, 1, 16'h0300, 0);
    runCycle();
    checkOutput("cap_then_gnt1", 1, obs_gnt1[1], 1);
    checkOutput("cap_then_gnt0", 1, obs_gnt0[1], 0);
    applyStimulus(1, 16'h0045, 1, 1, 16'h0301, 0);
    runCycle();
    checkOutput("cap_rr_favours0", 1, obs_gnt0[1], 1);
    idleCycles(3);

    $display("[TB] stray data and async reset");
    stray = 1'b1;
    runCycle();
    stray = 1'b0;
    idleCycles(4);
    checkOutput("stray_err_sticky", 0, err_v[0], 1);
    checkOutput("stray_err_sticky", 1, err_v[1], 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_err_clear", 0, err_v[0], 0);
    checkOutput("async_err_clear", 1, err_v[1], 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] full frame");
    f_idx = 0;
    h_cnt = 0;
    h_pend = 1'b0;
    h_addr = '0;
    guard = 0;
    rv0_cnt = 0;
    rv1_cnt = 0;
    while ((f_idx < 65536 || h_cnt < 256) && guard < 80000) begin
      if (!h_pend && h_cnt < 256 &&
          ($urandom_range(0, 199) == 0 || f_idx >= 65536)) begin
        h_pend = 1'b1;
        h_addr = 16'($urandom);
      end
      applyStimulus(f_idx < 65536, 16'(f_idx), 0, h_pend, h_addr, 0);
      runCycle();
      if (obs_rv0[0]) rv0_cnt++;
      if (obs_rv1[0]) rv1_cnt++;
      if (model_g[0] == 0) f_idx++;
      if (model_g[0] == 1) begin
        h_cnt++;
        h_pend = 1'b0;
      end
      guard++;
    end
    checkOutput("frame_done", 0, (f_idx == 65536 && h_cnt == 256), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      runCycle();
      if (obs_busy[0]) busy_cnt++;
      if (obs_rv0[0]) rv0_cnt++;
      if (obs_rv1[0]) rv1_cnt++;
    end
    checkOutput("busy_tail", 0, busy_cnt, GS_RD_LAT);
    checkOutput("frame_rvalid0_count", 0, rv0_cnt, 65536);
    checkOutput("frame_rvalid1_count", 0, rv1_cnt, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
